// File: rtl/sym_fir_pkg.sv
// Shared helpers and derived widths for the symmetric FIR filter.
// Widths are computed from the data, coefficient and tap parameters.
package sym_fir_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int n = 1; n < v; n = n * 2) r++;
    return r;
  endfunction

  function automatic int lat(input int taps);
    return 3 + clog2(taps / 2);
  endfunction

  function automatic int pair_w(input int dw);
    return dw + 1;
  endfunction

  function automatic int prod_w(input int dw, input int cw);
    return dw + cw + 1;
  endfunction

  function automatic int acc_w(input int dw, input int cw,
                               input int taps);
    return prod_w(dw, cw) + clog2(taps / 2);
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

  localparam int PAIR_W  = pair_w(16);
  localparam int PROD_W  = prod_w(16, 20);
  localparam int ACC_W   = acc_w(16, 20, 32);
  localparam int OUT_MAX = int'(sat_max(16));
  localparam int OUT_MIN = int'(sat_min(16));

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up, arithmetic shift and saturate of a wide accumulator.
// Purely combinational; the caller decides where to register it.
module fir_round_sat
  import sym_fir_pkg::*;
#(
  parameter int ACC_W     = 41,
  parameter int OUT_SHIFT = 16,
  parameter int OUT_W     = 16
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic [OUT_W-1:0]        data_o,
  output logic                    sat_o
);

  localparam int SW = ACC_W + 1;
  localparam logic signed [SW-1:0] HALF =
    SW'(longint'(1) << (OUT_SHIFT - 1));
  localparam logic signed [SW-1:0] MAXV = SW'(sat_max(OUT_W));
  localparam logic signed [SW-1:0] MINV = SW'(sat_min(OUT_W));

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] shr;

  always_comb begin
    sum    = SW'(acc_i) + HALF;
    shr    = sum >>> OUT_SHIFT;
    data_o = shr[OUT_W-1:0];
    sat_o  = 1'b0;
    if (shr > MAXV) begin
      data_o = MAXV[OUT_W-1:0];
      sat_o  = 1'b1;
    end else if (shr < MINV) begin
      data_o = MINV[OUT_W-1:0];
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/sym_fir_filter.sv
// Pipelined linear-phase FIR: pre-add, multiply, registered adder
// tree, then round/saturate, with a valid bit riding each sample.
module sym_fir_filter
  import sym_fir_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 20,
  parameter int TAPS      = 32,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic signed [DATA_W-1:0]        in_data,
  input  logic                            flush,
  input  logic                            coef_wr,
  input  logic [clog2(TAPS/2)-1:0]        coef_addr,
  input  logic signed [COEF_W-1:0]        coef_wdata,
  output logic                            out_valid,
  output logic [OUT_W-1:0]                out_data,
  output logic                            out_sat
);

  localparam int H  = TAPS / 2;
  localparam int NV = lat(TAPS) - 1;
  localparam int PW = pair_w(DATA_W);
  localparam int MW = prod_w(DATA_W, COEF_W);
  localparam int AW = acc_w(DATA_W, COEF_W, TAPS);
  localparam int FW = clog2(TAPS) + 1;

  logic signed [DATA_W-1:0] dly_q  [TAPS-1];
  logic signed [COEF_W-1:0] coef_q [H];
  logic signed [PW-1:0]     pair_q [H];
  logic signed [PW-1:0]     pair_d [H];
  logic signed [MW-1:0]     prod_q [H];
  logic signed [MW-1:0]     prod_d [H];
  logic signed [AW-1:0]     node_q [1:H-1];
  logic signed [AW-1:0]     node_d [1:H-1];
  logic [NV-1:0]            vld_q;
  logic [FW-1:0]            fill_q;
  logic                     out_valid_q;
  logic [OUT_W-1:0]         out_data_q;
  logic                     out_sat_q;
  logic [OUT_W-1:0]         rs_data;
  logic                     rs_sat;
  logic                     accept;
  logic                     gate;

  assign accept = in_valid & ~flush;
  assign gate   = fill_q >= FW'(TAPS - 1);

  for (genvar k = 0; k < H; k++) begin : gen_pair
    logic signed [DATA_W-1:0] xa;
    logic signed [DATA_W-1:0] xb;
    if (k == 0) begin : g_new
      assign xa = in_data;
    end else begin : g_old
      assign xa = dly_q[k-1];
    end
    assign xb        = dly_q[TAPS-2-k];
    assign pair_d[k] = PW'(xa) + PW'(xb);
    assign prod_d[k] = MW'(pair_q[k]) * MW'(coef_q[k]);
  end

  // Heap-ordered tree: node i sums children 2i and 2i+1; leaves are products.
  for (genvar i = 1; i < H; i++) begin : gen_tree
    if (2 * i >= H) begin : g_leaf
      assign node_d[i] = AW'(prod_q[2*i-H]) + AW'(prod_q[2*i+1-H]);
    end else begin : g_node
      assign node_d[i] = node_q[2*i] + node_q[2*i+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS - 1; i++) dly_q[i] <= '0;
      fill_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < TAPS - 1; i++) dly_q[i] <= '0;
      fill_q <= '0;
    end else if (in_valid) begin
      dly_q[0] <= in_data;
      for (int i = 1; i < TAPS - 1; i++) dly_q[i] <= dly_q[i-1];
      if (fill_q != FW'(TAPS)) fill_q <= fill_q + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < H; i++) coef_q[i] <= '0;
    end else if (coef_wr) begin
      coef_q[coef_addr] <= coef_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < H; i++) begin
        pair_q[i] <= '0;
        prod_q[i] <= '0;
      end
      for (int i = 1; i < H; i++) node_q[i] <= '0;
      vld_q <= '0;
    end else begin
      if (accept) pair_q <= pair_d;
      prod_q <= prod_d;
      node_q <= node_d;
      vld_q  <= flush ? '0 : {vld_q[NV-2:0], accept & gate};
    end
  end

  fir_round_sat #(
    .ACC_W     (AW),
    .OUT_SHIFT (OUT_SHIFT),
    .OUT_W     (OUT_W)
  ) u_round_sat (
    .acc_i  (node_q[1]),
    .data_o (rs_data),
    .sat_o  (rs_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= vld_q[NV-1];
      if (vld_q[NV-1]) begin
        out_data_q <= rs_data;
        out_sat_q  <= rs_sat;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_sym_fir_filter.sv
// Scoreboard bench for sym_fir_filter using a direct-form model.
// Expected outputs are queued at drive time and matched on out_valid.
module tb_sym_fir_filter;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic signed [15:0]  in_data;
  logic                flush;
  logic                coef_wr;
  logic [3:0]          coef_addr;
  logic signed [19:0]  coef_wdata;
  logic                out_valid;
  logic [15:0]         out_data;
  logic                out_sat;

  sym_fir_filter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .flush      (flush),
    .coef_wr    (coef_wr),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sat    (out_sat)
  );

  typedef struct {
    int due;
    int d;
    int s;
  } exp_t;

  exp_t q[$];
  int   mc[16];
  int   xh[32];
  int   fill_m;
  int   cyc_n;
  int   total;
  int   bad;
  int   last_d;
  int   last_s;
  bit   started;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_n = 0;
  always @(posedge clk) cyc_n++;

  function automatic void chk(input string tag,
                              input logic signed [39:0] o,
                              input logic signed [39:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, o, e);
    end
  endfunction

  function automatic void model_clear(input bit coefs);
    for (int i = 0; i < 32; i++) xh[i] = 0;
    fill_m = 0;
    q.delete();
    if (coefs) for (int i = 0; i < 16; i++) mc[i] = 0;
  endfunction

  function automatic void model_accept(input int d);
    longint y;
    longint r;
    exp_t   e;
    for (int i = 31; i > 0; i--) xh[i] = xh[i-1];
    xh[0] = d;
    if (fill_m < 32) fill_m++;
    if (fill_m == 32) begin
      y = 0;
      for (int t = 0; t < 32; t++)
        y += longint'(mc[t < 16 ? t : 31 - t]) * longint'(xh[t]);
      r = (y + 32768) >>> 16;
      e.s = 0;
      if (r > 32767) begin r = 32767; e.s = 1; end
      if (r < -32768) begin r = -32768; e.s = 1; end
      e.d = int'(r);
      e.due = cyc_n + 7;
      q.push_back(e);
    end
  endfunction

  task automatic tick(input bit v, input int d, input bit fl = 0,
                      input bit wr = 0, input int a = 0,
                      input int wd = 0);
    int dd;
    int ww;
    dd = d;
    ww = wd;
    in_valid   = v;
    in_data    = dd[15:0];
    flush      = fl;
    coef_wr    = wr;
    coef_addr  = 4'(a);
    coef_wdata = ww[19:0];
    if (wr) mc[a] = wd;
    if (fl) model_clear(1'b0);
    else if (v) model_accept(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    coef_wr  = 1'b0;
    rst_n    = 1'b0;
    model_clear(1'b1);
    last_d = 0;
    last_s = 0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", $signed(out_data), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (started && rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("latency", cyc_n, e.due);
          chk("data", $signed(out_data), e.d);
          chk("sat", out_sat, e.s);
          last_d = e.d;
          last_s = e.s;
        end
      end else begin
        if (q.size() > 0 && q[0].due <= cyc_n) begin
          e = q.pop_front();
          chk("missing_valid", 0, 1);
        end
        chk("hold_data", $signed(out_data), last_d);
        chk("hold_sat", out_sat, last_s);
      end
    end
  end

  initial begin
    int d;
    total = 0;
    bad = 0;
    started = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    flush = 1'b0;
    coef_wr = 1'b0;
    coef_addr = '0;
    coef_wdata = '0;
    model_clear(1'b1);
    last_d = 0;
    last_s = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", out_valid, 0);
    chk("reset_data", $signed(out_data), 0);
    chk("reset_sat", out_sat, 0);
    rst_n = 1'b1;
    started = 1'b1;
    idle(2);

    // DC gain
    for (int k = 0; k < 16; k++) tick(1'b0, 0, 1'b0, 1'b1, k, 65536);
    repeat (40) tick(1'b1, 100);
    idle(10);

    // gapped input after a flush
    tick(1'b0, 0, 1'b1);
    for (int i = 0; i < 80; i++) tick(i % 2 == 0, 10);
    idle(10);

    // saturation both ways
    repeat (34) tick(1'b1, 32767);
    repeat (34) tick(1'b1, -32768);
    idle(10);

    // flush with samples in flight
    repeat (5) tick(1'b1, 100);
    tick(1'b1, 100, 1'b1);
    repeat (33) tick(1'b1, 100);
    idle(10);

    // reset with samples in flight; coefficients return to zero
    repeat (5) tick(1'b1, 100);
    do_reset();
    repeat (33) tick(1'b1, 100);
    idle(10);

    // rounding with a single small centre coefficient
    tick(1'b0, 0, 1'b0, 1'b1, 15, 16384);
    repeat (33) tick(1'b1, 1);
    repeat (33) tick(1'b1, -1);
    idle(10);

    // coefficient update while streaming impulses
    tick(1'b0, 0, 1'b0, 1'b1, 15, 0);
    for (int i = 0; i < 40; i++) begin
      d = (i == 3 || i == 9 || i == 10 || i == 20) ? 1000 : 0;
      tick(1'b1, d, 1'b0, i == 10, 0, 65536);
    end
    idle(12);

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
